hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Central pipeline controller for the 5-stage MIPS core. Each cycle it decides whether each stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds or clears. It covers four cases: load-use hazards, taken-branch and jump squashing, data-memory wait states, and a memory-timeout error trap. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles that triggers the error trap (1..65535)
- CNT_W, 16, width of stall_cycles

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rs_id  in  5  source register Rs of instruction in ID
- rt_id  in  5  source register Rt of instruction in ID
- uses_rs_id  in  1  ID instruction reads Rs
- uses_rt_id  in  1  ID instruction reads Rt
- mem_read_ex  in  1  instruction in EX is a load
- write_reg_ex  in  5  destination register of instruction in EX
- branch_taken_ex  in  1  branch in EX resolved taken
- jump_id  in  1  jump decoded in ID
- dmem_req  in  1  MEM stage is accessing data memory this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_we  out  1  PC load enable
- if_id_we  out  1  IF/ID load enable
- if_id_clr  out  1  IF/ID loads zero (NOP)
- id_ex_we  out  1  ID/EX load enable
- id_ex_clr  out  1  ID/EX loads zero (bubble)
- ex_mem_we  out  1  EX/MEM load enable
- mem_wb_clr  out  1  MEM/WB loads zero (bubble)
- mem_err  out  1  sticky memory-timeout error
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. The state register and timeout counter are registered. Control outputs are combinational from state and inputs.
- Defaults in RUN: all *_we=1 and all *_clr=0.
- Freeze condition: (RUN and dmem_req and !dmem_ready) or state==MEM_WAIT and !dmem_ready.
  - During a freeze: pc_we, if_id_we, id_ex_we and ex_mem_we are 0; mem_wb_clr=1; all other clr outputs are 0.
  - In RUN with freeze, next state is MEM_WAIT.
  - In MEM_WAIT with dmem_ready=1, this is a release cycle: normal RUN evaluation applies and next state is RUN.
- Timeout counter:
  - Cleared on entry to MEM_WAIT and increments once per MEM_WAIT cycle.
  - When it reaches MEM_TIMEOUT with dmem_ready still 0, next state is ERROR.
- ERROR: permanent freeze with mem_err=1. Only reset leaves ERROR.
- Load-use hazard: mem_read_ex and write_reg_ex!=0 and ((uses_rs_id and rs_id==write_reg_ex) or (uses_rt_id and rt_id==write_reg_ex)).
  - Response: pc_we=0, if_id_we=0, id_ex_clr=1.
- Taken branch: if_id_clr=1, id_ex_clr=1, pc_we=1 so the PC takes the branch target.
- Jump: if_id_clr=1, pc_we=1.
- Priority, highest first: ERROR/freeze > branch_taken_ex > load-use > jump_id.
  - Branch with load-use: the branch wins and the stall is suppressed, because the dependent instruction is squashed.
  - Load-use with jump: the stall wins and the jump is not applied. The jump stays in ID and re-evaluates next cycle.
  - Branch or jump during a freeze: ignored while frozen. Upstream inputs are held, so the event is applied in the release cycle.
- stall_cycles increments on every clock where pc_we=0 and saturates at all-ones.

## Timing
- Reset: while reset=1, pc_we=0, if_id_we=0, id_ex_we=0, ex_mem_we=0, if_id_clr=1, id_ex_clr=1, mem_wb_clr=1. After the reset edge, state=RUN, timeout counter=0, mem_err=0, stall_cycles=0.
- Reset mid-MEM_WAIT or in ERROR returns to RUN on the next edge. The reset cycle does not increment stall_cycles.
- Load-use: exactly one bubble. The hazard clears the next cycle because the load has advanced to MEM.
- Latency: every control output responds in the same cycle as its inputs, with zero registered delay. State changes take effect on the next edge.
- dmem_ready=1 in the same cycle as the first dmem_req: no freeze and no MEM_WAIT entry.
- MEM_TIMEOUT=N: with dmem_ready held 0, ERROR is entered after N cycles in MEM_WAIT. mem_err rises on the following edge.

## Test plan
- Load-use: lw $8 in EX, add uses rs=$8 in ID → one cycle with pc_we=0, if_id_we=0, id_ex_clr=1, then normal; stall_cycles=1. Repeat with write_reg_ex=0 → no stall.
- Branch + load-use in the same cycle: branch_taken_ex=1 and hazard present → pc_we=1, if_id_clr=1, id_ex_clr=1; stall_cycles unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 → 3 freeze cycles with mem_wb_clr=1, release on the 4th cycle; stall_cycles=3.
- Timeout (MEM_TIMEOUT=4): dmem_ready held 0 → ERROR is entered and mem_err=1 stays high with dmem_ready later 1; reset → mem_err=0, state RUN.
- Jump vs load-use: jump_id=1 with hazard → stall first (if_id_clr=0), next cycle if_id_clr=1, pc_we=1.
- Saturation (CNT_W=4): force 20 freeze cycles → stall_cycles=15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Per-cycle load/hold/clear control for the 5-stage MIPS pipeline
//            registers, with memory wait/timeout trap and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic             mem_read_ex,
    input  logic [4:0]       write_reg_ex,
    input  logic             branch_taken_ex,
    input  logic             jump_id,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_clr,
    output logic             id_ex_we,
    output logic             id_ex_clr,
    output logic             ex_mem_we,
    output logic             mem_wb_clr,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    // Last MEM_WAIT cycle index before the trap fires (counter starts at 0).
    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [15:0]      tmo_q, tmo_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             freeze;
    logic             load_use;

    always_comb begin
        load_use = mem_read_ex && (write_reg_ex != 5'd0) &&
                   ((uses_rs_id && (rs_id == write_reg_ex)) ||
                    (uses_rt_id && (rt_id == write_reg_ex)));
    end

    always_comb begin
        freeze = (state_q == ST_ERROR) ||
                 ((state_q == ST_RUN) && dmem_req && !dmem_ready) ||
                 ((state_q == ST_MEM_WAIT) && !dmem_ready);
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        pc_we      = 1'b1;
        if_id_we   = 1'b1;
        if_id_clr  = 1'b0;
        id_ex_we   = 1'b1;
        id_ex_clr  = 1'b0;
        ex_mem_we  = 1'b1;
        mem_wb_clr = 1'b0;
        mem_err    = (state_q == ST_ERROR);

        if (reset) begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            ex_mem_we  = 1'b0;
            if_id_clr  = 1'b1;
            id_ex_clr  = 1'b1;
            mem_wb_clr = 1'b1;
        end else if (freeze) begin
            pc_we      = 1'b0;
            if_id_we   = 1'b0;
            id_ex_we   = 1'b0;
            ex_mem_we  = 1'b0;
            mem_wb_clr = 1'b1;
            case (state_q)
                ST_RUN: begin
                    state_d = ST_MEM_WAIT;
                    tmo_d   = 16'd0;
                end
                ST_MEM_WAIT: begin
                    if (tmo_q >= TMO_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_RUN;
            endcase
        end else begin
            // Not frozen: plain RUN, or the release cycle out of MEM_WAIT.
            if (state_q != ST_RUN) begin
                state_d = ST_RUN;
            end
            if (branch_taken_ex) begin
                if_id_clr = 1'b1;
                id_ex_clr = 1'b1;
            end else if (load_use) begin
                pc_we     = 1'b0;
                if_id_we  = 1'b0;
                id_ex_clr = 1'b1;
            end else if (jump_id) begin
                if_id_clr = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_we && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            tmo_q   <= 16'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed and randomized checks of hazard_stall_ctrl against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs_id, rt_id, write_reg_ex;
    logic          uses_rs_id, uses_rt_id, mem_read_ex;
    logic          branch_taken_ex, jump_id, dmem_req, dmem_ready;
    logic          pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr;
    logic          ex_mem_we, mem_wb_clr, mem_err;
    logic [CW-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Model state: waiting in memory stall, cycles spent waiting, trapped, stall count.
    bit m_wait;
    int m_waitn;
    bit m_err;
    int m_cnt;

    hazard_stall_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .mem_read_ex(mem_read_ex), .write_reg_ex(write_reg_ex),
        .branch_taken_ex(branch_taken_ex), .jump_id(jump_id),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_clr(if_id_clr),
        .id_ex_we(id_ex_we), .id_ex_clr(id_ex_clr), .ex_mem_we(ex_mem_we),
        .mem_wb_clr(mem_wb_clr), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt, input bit mr, input logic [4:0] wr,
                        input bit br, input bit jp, input bit rq, input bit rd);
        bit frz, lu;
        bit e_pc, e_ifwe, e_ifclr, e_idwe, e_idclr, e_exwe, e_wbclr;
        @(posedge clk);
        #1;
        reset = rst; rs_id = rs; rt_id = rt; uses_rs_id = urs; uses_rt_id = urt;
        mem_read_ex = mr; write_reg_ex = wr; branch_taken_ex = br; jump_id = jp;
        dmem_req = rq; dmem_ready = rd;
        @(negedge clk);

        frz = m_err || (!rd && (m_wait || rq));
        lu  = mr && (wr != 5'd0) && ((urs && rs == wr) || (urt && rt == wr));
        {e_pc, e_ifwe, e_idwe, e_exwe} = 4'b1111;
        {e_ifclr, e_idclr, e_wbclr}    = 3'b000;
        if (rst) begin
            {e_pc, e_ifwe, e_idwe, e_exwe} = 4'b0000;
            {e_ifclr, e_idclr, e_wbclr}    = 3'b111;
        end else if (frz) begin
            {e_pc, e_ifwe, e_idwe, e_exwe} = 4'b0000;
            e_wbclr = 1'b1;
        end else if (br) begin
            e_ifclr = 1'b1; e_idclr = 1'b1;
        end else if (lu) begin
            e_pc = 1'b0; e_ifwe = 1'b0; e_idclr = 1'b1;
        end else if (jp) begin
            e_ifclr = 1'b1;
        end

        check("ctl{pc,ifwe,ifclr,idwe,idclr,exwe,wbclr}",
              {25'd0, pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr, ex_mem_we, mem_wb_clr},
              {25'd0, e_pc, e_ifwe, e_ifclr, e_idwe, e_idclr, e_exwe, e_wbclr});
        if (!rst) check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
        check("stall_cycles", {{(32-CW){1'b0}}, stall_cycles}, m_cnt);

        if (rst) begin
            m_wait = 0; m_waitn = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (!e_pc && m_cnt < (2**CW) - 1) m_cnt++;
            if (!m_err) begin
                if (frz) begin
                    if (!m_wait) begin
                        m_wait = 1; m_waitn = 0;
                    end else begin
                        m_waitn++;
                        if (m_waitn >= TMO) m_err = 1;
                    end
                end else begin
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic idle();
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; rs_id = '0; rt_id = '0; uses_rs_id = 0; uses_rt_id = 0;
        mem_read_ex = 0; write_reg_ex = '0; branch_taken_ex = 0; jump_id = 0;
        dmem_req = 0; dmem_ready = 0;
        repeat (2) @(posedge clk);
        m_wait = 0; m_waitn = 0; m_err = 0; m_cnt = 0;

        // Reset outputs, then load-use: lw $8 / add using $8 -> one bubble.
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        step(0, 5'd8, 5'd3, 1, 1, 1, 5'd8, 0, 0, 0, 0);
        idle();
        check("loaduse_stall_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'd1);
        // Destination $0 never stalls.
        step(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 0);
        idle();
        check("r0_no_stall_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'd1);

        // Branch beats load-use.
        step(0, 5'd5, 5'd5, 1, 0, 1, 5'd5, 1, 0, 0, 0);
        idle();
        check("branch_lu_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'd1);

        // Jump with load-use: stall first, then jump.
        step(0, 5'd7, 5'd9, 0, 1, 1, 5'd9, 0, 1, 0, 0);
        step(0, 5'd7, 5'd9, 0, 1, 0, 5'd0, 0, 1, 0, 0);
        check("jump_after_stall_ifclr", {31'd0, if_id_clr}, 32'd1);

        // Memory wait: 3 freeze cycles then release.
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        repeat (3) step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 1, 1);
        idle();
        check("memwait_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'd3);

        // Ready with first request: no freeze.
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 1, 1);
        check("ready_first_pc_we", {31'd0, pc_we}, 32'd1);

        // Timeout: 1 RUN freeze + TMO MEM_WAIT cycles -> ERROR, sticky.
        repeat (1 + TMO) step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 1, 0);
        step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 1, 1, 1, 1);
        check("timeout_mem_err", {31'd0, mem_err}, 32'd1);
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        idle();
        check("reset_clears_err", {31'd0, mem_err}, 32'd0);

        // Saturation of the 4-bit counter.
        repeat (20) step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 1, 0);
        idle();
        check("sat_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'd15);

        // Randomized traffic.
        step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
